proc_ctrl_multi: RTL and testbench
==================================

# proc_ctrl_multi

Multi-stage match-action sequencer for the packet processor. It sequences one external parser, one matcher and one executor through a configurable chain of up to NUM_STAGES match/execute stages per packet, with per-stage hit/miss action addresses. It supports executor-requested drops, exposes packet statistics counters and has an optional watchdog. It sits between the input header FIFO and the output header FIFO and replaces the single-stage controller.

## Interface
Parameters:
- NUM_STAGES, 4: maximum match/execute stages per packet (≥1); SW = max(1, $clog2(NUM_STAGES)).
- ADDR_W, 32: action address width.
- CNT_W, 32: statistics counter width.
- TIMEOUT, 1024: watchdog limit in cycles (≥2).

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_empty_i  in  1  input FIFO empty.
- in_rd_o  out  1  one-cycle pop of input FIFO.
- out_full_i  in  1  output FIFO full.
- out_wr_o  out  1  one-cycle push to output FIFO.
- ps_start_o  out  1  parser start pulse.
- ps_ready_i  in  1  parser done.
- mt_start_o  out  1  matcher start pulse.
- mt_stage_o  out  SW  stage index being matched.
- mt_ready_i  in  1  matcher done.
- mt_is_match_i  in  1  hit flag, valid with mt_ready_i.
- ex_start_o  out  1  executor start pulse.
- ex_op_start_cnt_o  out  ADDR_W  action start address.
- ex_ready_i  in  1  executor done.
- ex_drop_i  in  1  drop request, valid with ex_ready_i.
- cfg_we_i  in  1  write hit/miss addresses of stage cfg_stage_i.
- cfg_stage_i  in  SW  stage written.
- cfg_hit_addr_i  in  ADDR_W  hit action address.
- cfg_miss_addr_i  in  ADDR_W  miss action address.
- cfg_len_we_i  in  1  write active stage count.
- cfg_num_stages_i  in  SW+1  active stage count.
- cfg_busy_o  out  1  high whenever state ≠ FREE.
- pkt_cnt_o  out  CNT_W  packets forwarded.
- drop_cnt_o  out  CNT_W  packets dropped (executor or watchdog).
- hit_cnt_o  out  CNT_W  matcher hits, summed over all stages.
- timeout_cnt_o  out  CNT_W  watchdog expiries.
- err_o  out  1  one-cycle pulse on watchdog expiry.

## Operation
- States: FREE, PARSE, MATCH, EXEC, OUT_WAIT, LATCH.
- FREE:
  - cfg_we_i or cfg_len_we_i has priority over packet start. If either is high, the write(s) are applied and no packet starts that cycle.
  - Otherwise, if in_empty_i=0: pulse ps_start_o, set stage=0, go to PARSE.
  - Configuration writes in any other state are ignored.
- Configuration rules:
  - cfg_num_stages_i=0 is ignored.
  - Values >NUM_STAGES saturate to NUM_STAGES.
  - cfg_stage_i ≥NUM_STAGES is ignored.
- PARSE: on ps_ready_i, pulse mt_start_o with mt_stage_o=stage, go to MATCH.
- MATCH: on mt_ready_i, pulse ex_start_o with ex_op_start_cnt_o = hit_addr[stage] if mt_is_match_i, else miss_addr[stage]. Increment hit_cnt on a hit. Go to EXEC.
- EXEC, on ex_ready_i:
  - ex_drop_i=1: pulse in_rd_o only, increment drop_cnt, go to LATCH.
  - Else if stage < num_stages−1: stage++, pulse mt_start_o, go to MATCH.
  - Else go to OUT_WAIT.
- OUT_WAIT: when out_full_i=0, pulse in_rd_o and out_wr_o together, increment pkt_cnt, go to LATCH. There is no time limit in this state.
- LATCH: all pulses low; go to FREE.
- Ready inputs are ignored in the cycle where the matching start_o is high. Ready inputs are ignored outside their own wait state.
- mt_stage_o and ex_op_start_cnt_o hold their values until next written.
- Counters wrap modulo 2^CNT_W.
- Reset values:
  - All outputs, counters and stage are 0; state = FREE.
  - num_stages = 1; all hit/miss addresses = 0.
- Reset mid-packet aborts without popping the FIFO. The packet is reprocessed after reset.

## Timing
- All outputs are registered.
- Start/rd/wr pulses last exactly one cycle.
- The first pulse appears the cycle after the triggering condition is sampled.
- One-stage packet with 1-cycle sub-blocks: in_empty_i sampled low at cycle 0 gives:
  - ps_start_o at cycle 1.
  - mt_start_o at cycle 3.
  - ex_start_o at cycle 5.
  - out_wr_o at cycle 7 if out_full_i=0 at cycle 6.
  - FREE at cycle 8.
- Each extra stage adds 4 cycles.
- Back-to-back packets: the next ps_start_o comes 2 cycles after in_rd_o.

## Configuration
- PROC_WATCHDOG_EN defined:
  - A cycle counter clears on each ps_start_o, mt_start_o or ex_start_o.
  - If it reaches TIMEOUT in PARSE, MATCH or EXEC without the matching ready, the controller:
    - pulses in_rd_o and err_o;
    - increments drop_cnt and timeout_cnt;
    - goes to LATCH.
- PROC_WATCHDOG_EN undefined: waits are unbounded; timeout_cnt_o and err_o are tied to 0.

## Test plan
- Single stage, hit: num_stages=1, hit_addr[0]=0x40, mt_is_match_i=1 -> ex_op_start_cnt_o=0x40, one out_wr_o, pkt_cnt=1, hit_cnt=1, 8-cycle latency.
- Three stages, pattern hit/miss/hit, miss_addr[1]=0x80 -> mt_stage_o goes 0,1,2; addresses hit0, 0x80, hit2; hit_cnt=2; one in_rd_o/out_wr_o pair.
- Drop: ex_drop_i=1 at stage 0 of 2 -> in_rd_o pulse, no out_wr_o, no stage-1 match, drop_cnt=1.
- Backpressure and config blocking: out_full_i high 10 cycles -> state held in OUT_WAIT, out_wr_o on the cycle after deassertion; cfg_we_i while busy -> addresses unchanged. Same-cycle cfg_we_i and in_empty_i=0 in FREE -> config applied, packet start delayed 1 cycle.
- Config limits: cfg_num_stages_i=0 -> no change; cfg_num_stages_i=NUM_STAGES+1 -> saturates to NUM_STAGES.
- Watchdog (PROC_WATCHDOG_EN, TIMEOUT=16): mt_ready_i never asserted -> err_o and in_rd_o 16 cycles after mt_start_o, timeout_cnt=1. Reset mid-EXEC -> all outputs 0, num_stages=1 next cycle.

Source files
------------

// File: rtl/proc_ctrl_multi.sv
// Match-action sequencer: parser, then up to NUM_STAGES matcher/executor rounds per packet, then output push.
// Registered outputs, waits on out_full_i in OUT_WAIT; define PROC_WATCHDOG_EN for the sub-block watchdog.
module proc_ctrl_multi #(
   parameter int NUM_STAGES = 4,
   parameter int ADDR_W     = 32,
   parameter int CNT_W      = 32,
   parameter int TIMEOUT    = 1024,
   localparam int SW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_empty_i,
   output logic              in_rd_o,
   input  logic              out_full_i,
   output logic              out_wr_o,
   output logic              ps_start_o,
   input  logic              ps_ready_i,
   output logic              mt_start_o,
   output logic [SW-1:0]     mt_stage_o,
   input  logic              mt_ready_i,
   input  logic              mt_is_match_i,
   output logic              ex_start_o,
   output logic [ADDR_W-1:0] ex_op_start_cnt_o,
   input  logic              ex_ready_i,
   input  logic              ex_drop_i,
   input  logic              cfg_we_i,
   input  logic [SW-1:0]     cfg_stage_i,
   input  logic [ADDR_W-1:0] cfg_hit_addr_i,
   input  logic [ADDR_W-1:0] cfg_miss_addr_i,
   input  logic              cfg_len_we_i,
   input  logic [SW:0]       cfg_num_stages_i,
   output logic              cfg_busy_o,
   output logic [CNT_W-1:0]  pkt_cnt_o,
   output logic [CNT_W-1:0]  drop_cnt_o,
   output logic [CNT_W-1:0]  hit_cnt_o,
   output logic [CNT_W-1:0]  timeout_cnt_o,
   output logic              err_o
);
   typedef enum logic [2:0] {FREE, PARSE, MATCH, EXEC, OUT_WAIT, LATCH} state_t;

   localparam logic [SW:0] ONE        = (SW+1)'(1);
   localparam logic [SW:0] MAX_STAGES = (SW+1)'(NUM_STAGES);

   state_t            state, state_nxt;
   logic [SW-1:0]     stage, stage_nxt;
   logic [SW:0]       num_stages;
   logic [ADDR_W-1:0] hit_addr  [NUM_STAGES];
   logic [ADDR_W-1:0] miss_addr [NUM_STAGES];

   logic ps_acc, mt_acc, ex_acc, wd_exp, cfg_any, more_stages;
   logic ps_start_nxt, mt_start_nxt, ex_start_nxt, rd_nxt, wr_nxt;
   logic hit_inc, drop_inc;

   // A ready arriving together with its own start pulse belongs to the previous request.
   assign ps_acc      = (state == PARSE) && ps_ready_i && !ps_start_o;
   assign mt_acc      = (state == MATCH) && mt_ready_i && !mt_start_o;
   assign ex_acc      = (state == EXEC)  && ex_ready_i && !ex_start_o;
   assign cfg_any     = cfg_we_i | cfg_len_we_i;
   assign more_stages = ({1'b0, stage} + ONE) < num_stages;

`ifdef PROC_WATCHDOG_EN
   localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   logic [WD_W-1:0]  wd_cnt;
   logic [CNT_W-1:0] timeout_cnt;
   logic             err_q;

   assign wd_exp = (wd_cnt == WD_LAST) &&
                   (((state == PARSE) && !ps_acc) ||
                    ((state == MATCH) && !mt_acc) ||
                    ((state == EXEC)  && !ex_acc));

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt      <= '0;
         timeout_cnt <= '0;
         err_q       <= 1'b0;
      end else begin
         err_q <= wd_exp;
         if (wd_exp) timeout_cnt <= timeout_cnt + CNT_W'(1);
         if (ps_start_nxt || mt_start_nxt || ex_start_nxt) wd_cnt <= '0;
         else if (wd_cnt != WD_LAST)                       wd_cnt <= wd_cnt + WD_W'(1);
      end
   end

   assign timeout_cnt_o = timeout_cnt;
   assign err_o         = err_q;
`else
   assign wd_exp        = 1'b0;
   assign timeout_cnt_o = '0;
   assign err_o         = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FREE;
         stage <= '0;
      end else begin
         state <= state_nxt;
         stage <= stage_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FREE:     if (!cfg_any && !in_empty_i) state_nxt = PARSE;
         PARSE:    if (wd_exp) state_nxt = LATCH; else if (ps_acc) state_nxt = MATCH;
         MATCH:    if (wd_exp) state_nxt = LATCH; else if (mt_acc) state_nxt = EXEC;
         EXEC: begin
            if (wd_exp)                        state_nxt = LATCH;
            else if (ex_acc && ex_drop_i)      state_nxt = LATCH;
            else if (ex_acc && more_stages)    state_nxt = MATCH;
            else if (ex_acc && !out_full_i)    state_nxt = LATCH;
            else if (ex_acc)                   state_nxt = OUT_WAIT;
         end
         OUT_WAIT: if (!out_full_i) state_nxt = LATCH;
         LATCH:    state_nxt = FREE;
         default:  state_nxt = FREE;
      endcase
   end

   // The last stage pushes straight from EXEC when the output FIFO has room.
   always_comb begin
      ps_start_nxt = 1'b0;
      mt_start_nxt = 1'b0;
      ex_start_nxt = 1'b0;
      rd_nxt       = 1'b0;
      wr_nxt       = 1'b0;
      hit_inc      = 1'b0;
      drop_inc     = 1'b0;
      stage_nxt    = stage;
      case (state)
         FREE: if (!cfg_any && !in_empty_i) begin
            ps_start_nxt = 1'b1;
            stage_nxt    = '0;
         end
         PARSE: if (ps_acc) mt_start_nxt = 1'b1;
         MATCH: if (mt_acc) begin
            ex_start_nxt = 1'b1;
            hit_inc      = mt_is_match_i;
         end
         EXEC: if (ex_acc) begin
            if (ex_drop_i) begin
               rd_nxt   = 1'b1;
               drop_inc = 1'b1;
            end else if (more_stages) begin
               stage_nxt    = stage + SW'(1);
               mt_start_nxt = 1'b1;
            end else if (!out_full_i) begin
               rd_nxt = 1'b1;
               wr_nxt = 1'b1;
            end
         end
         OUT_WAIT: if (!out_full_i) begin
            rd_nxt = 1'b1;
            wr_nxt = 1'b1;
         end
         default: ;
      endcase
      if (wd_exp) begin
         rd_nxt   = 1'b1;
         drop_inc = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ps_start_o        <= 1'b0;
         mt_start_o        <= 1'b0;
         ex_start_o        <= 1'b0;
         in_rd_o           <= 1'b0;
         out_wr_o          <= 1'b0;
         cfg_busy_o        <= 1'b0;
         mt_stage_o        <= '0;
         ex_op_start_cnt_o <= '0;
         pkt_cnt_o         <= '0;
         drop_cnt_o        <= '0;
         hit_cnt_o         <= '0;
      end else begin
         ps_start_o <= ps_start_nxt;
         mt_start_o <= mt_start_nxt;
         ex_start_o <= ex_start_nxt;
         in_rd_o    <= rd_nxt;
         out_wr_o   <= wr_nxt;
         cfg_busy_o <= (state_nxt != FREE);
         if (mt_start_nxt) mt_stage_o <= stage_nxt;
         if (ex_start_nxt) ex_op_start_cnt_o <= mt_is_match_i ? hit_addr[stage] : miss_addr[stage];
         if (wr_nxt)   pkt_cnt_o  <= pkt_cnt_o + CNT_W'(1);
         if (drop_inc) drop_cnt_o <= drop_cnt_o + CNT_W'(1);
         if (hit_inc)  hit_cnt_o  <= hit_cnt_o + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         num_stages <= ONE;
         for (int i = 0; i < NUM_STAGES; i++) begin
            hit_addr[i]  <= '0;
            miss_addr[i] <= '0;
         end
      end else if (state == FREE) begin
         if (cfg_we_i && (int'(cfg_stage_i) < NUM_STAGES)) begin
            hit_addr[cfg_stage_i]  <= cfg_hit_addr_i;
            miss_addr[cfg_stage_i] <= cfg_miss_addr_i;
         end
         if (cfg_len_we_i && (cfg_num_stages_i != '0))
            num_stages <= (cfg_num_stages_i > MAX_STAGES) ? MAX_STAGES : cfg_num_stages_i;
      end
   end
endmodule

// File: tb/tb_proc_ctrl_multi.sv
// Directed bench for proc_ctrl_multi: 1-cycle parser/matcher/executor responders driven cycle by cycle.
`timescale 1ns/1ps
module tb_proc_ctrl_multi;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_empty_i, in_rd_o, out_full_i, out_wr_o;
   logic        ps_start_o, ps_ready_i, mt_start_o, mt_ready_i, mt_is_match_i;
   logic [1:0]  mt_stage_o;
   logic        ex_start_o, ex_ready_i, ex_drop_i;
   logic [31:0] ex_op_start_cnt_o;
   logic        cfg_we_i, cfg_len_we_i, cfg_busy_o, err_o;
   logic [1:0]  cfg_stage_i;
   logic [31:0] cfg_hit_addr_i, cfg_miss_addr_i;
   logic [2:0]  cfg_num_stages_i;
   logic [31:0] pkt_cnt_o, drop_cnt_o, hit_cnt_o, timeout_cnt_o;

   int total = 0;
   int bad   = 0;

   int ps_cyc, mt_cyc, ex_cyc, wr_cyc, rd_cyc, free_cyc, err_cyc;
   int mt_n, ex_n, rd_n, wr_n, err_n;
   int          mt_stages [8];
   logic [31:0] ex_addrs  [8];

   proc_ctrl_multi #(.NUM_STAGES(4), .ADDR_W(32), .CNT_W(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .in_empty_i(in_empty_i), .in_rd_o(in_rd_o), .out_full_i(out_full_i), .out_wr_o(out_wr_o),
      .ps_start_o(ps_start_o), .ps_ready_i(ps_ready_i),
      .mt_start_o(mt_start_o), .mt_stage_o(mt_stage_o), .mt_ready_i(mt_ready_i), .mt_is_match_i(mt_is_match_i),
      .ex_start_o(ex_start_o), .ex_op_start_cnt_o(ex_op_start_cnt_o), .ex_ready_i(ex_ready_i), .ex_drop_i(ex_drop_i),
      .cfg_we_i(cfg_we_i), .cfg_stage_i(cfg_stage_i), .cfg_hit_addr_i(cfg_hit_addr_i), .cfg_miss_addr_i(cfg_miss_addr_i),
      .cfg_len_we_i(cfg_len_we_i), .cfg_num_stages_i(cfg_num_stages_i), .cfg_busy_o(cfg_busy_o),
      .pkt_cnt_o(pkt_cnt_o), .drop_cnt_o(drop_cnt_o), .hit_cnt_o(hit_cnt_o),
      .timeout_cnt_o(timeout_cnt_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input int stg, input logic [31:0] h, input logic [31:0] m);
      cfg_we_i = 1'b1; cfg_stage_i = 2'(stg); cfg_hit_addr_i = h; cfg_miss_addr_i = m;
      tick;
      cfg_we_i = 1'b0;
   endtask

   task automatic cfg_len(input int n);
      cfg_len_we_i = 1'b1; cfg_num_stages_i = 3'(n);
      tick;
      cfg_len_we_i = 1'b0;
   endtask

   // Cycle 0 is the cycle in_empty_i is first presented low; records event cycles relative to it.
   // stall: 1 = matcher never answers, 2 = executor never answers.
   task automatic run_pkt(input logic [3:0] pat, input int drop_stage, input int full_to,
                          input bit keep, input int stall, input bit busy_cfg, input int budget);
      bit p_ps, p_mt, p_ex, rd_seen;
      ps_cyc = -1; mt_cyc = -1; ex_cyc = -1; wr_cyc = -1; rd_cyc = -1; free_cyc = -1; err_cyc = -1;
      mt_n = 0; ex_n = 0; rd_n = 0; wr_n = 0; err_n = 0;
      p_ps = 0; p_mt = 0; p_ex = 0; rd_seen = 0;
      in_empty_i = 1'b0;
      out_full_i = (full_to > 0);
      for (int c = 1; c <= budget; c++) begin
         tick;
         ps_ready_i    = p_ps;
         mt_ready_i    = p_mt;
         ex_ready_i    = p_ex;
         mt_is_match_i = 1'b0;
         if (p_mt) mt_is_match_i = pat[mt_n-1];
         ex_drop_i     = p_ex && ((ex_n - 1) == drop_stage);
         out_full_i    = (c < full_to);
         cfg_we_i      = busy_cfg && (c == 10);
         cfg_len_we_i  = busy_cfg && (c == 10);
         cfg_stage_i = 2'd0; cfg_hit_addr_i = 32'hDEAD; cfg_miss_addr_i = 32'hBEEF; cfg_num_stages_i = 3'd3;
         p_ps = ps_start_o;
         p_mt = mt_start_o && (stall != 1);
         p_ex = ex_start_o && (stall != 2);
         if (rd_seen && !cfg_busy_o) begin
            free_cyc = c;
            break;
         end
         if (ps_start_o) begin
            ps_cyc = c;
            if (!keep) in_empty_i = 1'b1;
         end
         if (mt_start_o) begin
            if (mt_cyc < 0) mt_cyc = c;
            if (mt_n < 8) mt_stages[mt_n] = int'(mt_stage_o);
            mt_n++;
         end
         if (ex_start_o) begin
            if (ex_cyc < 0) ex_cyc = c;
            if (ex_n < 8) ex_addrs[ex_n] = ex_op_start_cnt_o;
            ex_n++;
         end
         if (in_rd_o)  begin rd_n++;  rd_cyc = c; rd_seen = 1; end
         if (out_wr_o) begin wr_n++;  wr_cyc = c; end
         if (err_o)    begin err_n++; err_cyc = c; end
      end
      ps_ready_i = 0; mt_ready_i = 0; ex_ready_i = 0; ex_drop_i = 0; mt_is_match_i = 0;
      out_full_i = 0; cfg_we_i = 0; cfg_len_we_i = 0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick; tick;
      total++; if ({ps_start_o, mt_start_o, ex_start_o, in_rd_o, out_wr_o, cfg_busy_o, err_o} !== 7'b0) begin bad++; $display("FAIL reset_pulses got=%b want=0", {ps_start_o, mt_start_o, ex_start_o, in_rd_o, out_wr_o, cfg_busy_o, err_o}); end
      total++; if ({pkt_cnt_o, drop_cnt_o, hit_cnt_o, timeout_cnt_o} !== 128'b0) begin bad++; $display("FAIL reset_counters got=%0h/%0h/%0h/%0h want=0", pkt_cnt_o, drop_cnt_o, hit_cnt_o, timeout_cnt_o); end
      total++; if ({mt_stage_o, ex_op_start_cnt_o} !== 34'b0) begin bad++; $display("FAIL reset_regs got=%0h/%0h want=0", mt_stage_o, ex_op_start_cnt_o); end
      rst = 1'b0;
      tick;
   endtask

   task automatic test_single_hit;
      cfg_write(0, 32'h40, 32'h41);
      cfg_len(1);
      run_pkt(4'b0001, -1, 0, 0, 0, 0, 60);
      total++; if (ps_cyc !== 1) begin bad++; $display("FAIL single_ps_cyc got=%0d want=1", ps_cyc); end
      total++; if (mt_cyc !== 3) begin bad++; $display("FAIL single_mt_cyc got=%0d want=3", mt_cyc); end
      total++; if (ex_cyc !== 5) begin bad++; $display("FAIL single_ex_cyc got=%0d want=5", ex_cyc); end
      total++; if (ex_addrs[0] !== 32'h40) begin bad++; $display("FAIL single_addr got=%0h want=40", ex_addrs[0]); end
      total++; if (wr_cyc !== 7 || rd_cyc !== 7) begin bad++; $display("FAIL single_wr_rd_cyc got=%0d/%0d want=7/7", wr_cyc, rd_cyc); end
      total++; if (wr_n !== 1 || rd_n !== 1) begin bad++; $display("FAIL single_wr_rd_n got=%0d/%0d want=1/1", wr_n, rd_n); end
      total++; if (free_cyc !== 8) begin bad++; $display("FAIL single_free_cyc got=%0d want=8", free_cyc); end
      total++; if (pkt_cnt_o !== 1 || hit_cnt_o !== 1) begin bad++; $display("FAIL single_cnt got=%0d/%0d want=1/1", pkt_cnt_o, hit_cnt_o); end
   endtask

   task automatic test_three_stage;
      cfg_write(1, 32'h90, 32'h80);
      cfg_write(2, 32'hC0, 32'hC1);
      cfg_len(3);
      run_pkt(4'b0101, -1, 0, 0, 0, 0, 60);
      total++; if (mt_n !== 3) begin bad++; $display("FAIL three_mt_n got=%0d want=3", mt_n); end
      total++; if (mt_stages[0] !== 0 || mt_stages[1] !== 1 || mt_stages[2] !== 2) begin bad++; $display("FAIL three_stages got=%0d,%0d,%0d want=0,1,2", mt_stages[0], mt_stages[1], mt_stages[2]); end
      total++; if (ex_addrs[0] !== 32'h40 || ex_addrs[1] !== 32'h80 || ex_addrs[2] !== 32'hC0) begin bad++; $display("FAIL three_addrs got=%0h,%0h,%0h want=40,80,c0", ex_addrs[0], ex_addrs[1], ex_addrs[2]); end
      total++; if (wr_cyc !== 15) begin bad++; $display("FAIL three_wr_cyc got=%0d want=15", wr_cyc); end
      total++; if (wr_n !== 1 || rd_n !== 1) begin bad++; $display("FAIL three_wr_rd_n got=%0d/%0d want=1/1", wr_n, rd_n); end
      total++; if (hit_cnt_o !== 3 || pkt_cnt_o !== 2) begin bad++; $display("FAIL three_cnt got=%0d/%0d want=3/2", hit_cnt_o, pkt_cnt_o); end
   endtask

   task automatic test_drop;
      cfg_len(2);
      run_pkt(4'b0001, 0, 0, 0, 0, 0, 60);
      total++; if (rd_n !== 1 || rd_cyc !== 7) begin bad++; $display("FAIL drop_rd got=%0d@%0d want=1@7", rd_n, rd_cyc); end
      total++; if (wr_n !== 0) begin bad++; $display("FAIL drop_wr_n got=%0d want=0", wr_n); end
      total++; if (mt_n !== 1) begin bad++; $display("FAIL drop_mt_n got=%0d want=1", mt_n); end
      total++; if (drop_cnt_o !== 1 || pkt_cnt_o !== 2) begin bad++; $display("FAIL drop_cnt got=%0d/%0d want=1/2", drop_cnt_o, pkt_cnt_o); end
      total++; if (free_cyc !== 8) begin bad++; $display("FAIL drop_free_cyc got=%0d want=8", free_cyc); end
   endtask

   task automatic test_backpressure;
      cfg_len(1);
      run_pkt(4'b0000, -1, 16, 0, 0, 1, 60);
      total++; if (ex_addrs[0] !== 32'h41) begin bad++; $display("FAIL bp_miss_addr got=%0h want=41", ex_addrs[0]); end
      total++; if (wr_cyc !== 17 || wr_n !== 1) begin bad++; $display("FAIL bp_wr got=%0d@%0d want=1@17", wr_n, wr_cyc); end
      total++; if (free_cyc !== 18) begin bad++; $display("FAIL bp_free_cyc got=%0d want=18", free_cyc); end
      run_pkt(4'b0001, -1, 0, 0, 0, 0, 60);
      total++; if (ex_addrs[0] !== 32'h40) begin bad++; $display("FAIL busy_cfg_addr got=%0h want=40", ex_addrs[0]); end
      total++; if (mt_n !== 1) begin bad++; $display("FAIL busy_cfg_len got=%0d want=1", mt_n); end
      total++; if (pkt_cnt_o !== 4 || hit_cnt_o !== 5) begin bad++; $display("FAIL bp_cnt got=%0d/%0d want=4/5", pkt_cnt_o, hit_cnt_o); end
   endtask

   task automatic test_cfg_same_cycle;
      in_empty_i = 1'b0;
      cfg_write(0, 32'h44, 32'h41);
      total++; if (ps_start_o !== 1'b0 || cfg_busy_o !== 1'b0) begin bad++; $display("FAIL samecyc_blocked got=%b%b want=00", ps_start_o, cfg_busy_o); end
      run_pkt(4'b0001, -1, 0, 0, 0, 0, 60);
      total++; if (ps_cyc !== 1) begin bad++; $display("FAIL samecyc_ps_cyc got=%0d want=1", ps_cyc); end
      total++; if (ex_addrs[0] !== 32'h44) begin bad++; $display("FAIL samecyc_addr got=%0h want=44", ex_addrs[0]); end
   endtask

   task automatic test_cfg_limits;
      cfg_len(0);
      run_pkt(4'b0000, -1, 0, 0, 0, 0, 60);
      total++; if (mt_n !== 1) begin bad++; $display("FAIL len0_mt_n got=%0d want=1", mt_n); end
      cfg_len(5);
      run_pkt(4'b0000, -1, 0, 0, 0, 0, 80);
      total++; if (mt_n !== 4 || mt_stages[3] !== 3) begin bad++; $display("FAIL len_sat got=%0d last=%0d want=4 last=3", mt_n, mt_stages[3]); end
      total++; if (wr_cyc !== 19) begin bad++; $display("FAIL len_sat_wr_cyc got=%0d want=19", wr_cyc); end
      total++; if (pkt_cnt_o !== 7 || hit_cnt_o !== 6) begin bad++; $display("FAIL limits_cnt got=%0d/%0d want=7/6", pkt_cnt_o, hit_cnt_o); end
   endtask

   task automatic test_back_to_back;
      cfg_len(1);
      run_pkt(4'b0001, -1, 0, 1, 0, 0, 60);
      total++; if (rd_cyc !== 7 || free_cyc !== 8) begin bad++; $display("FAIL b2b_first got=%0d/%0d want=7/8", rd_cyc, free_cyc); end
      run_pkt(4'b0001, -1, 0, 0, 0, 0, 60);
      total++; if (ps_cyc !== 1) begin bad++; $display("FAIL b2b_ps_gap got=%0d want=1", ps_cyc); end
      total++; if (wr_cyc !== 7 || ex_addrs[0] !== 32'h44) begin bad++; $display("FAIL b2b_second got=%0d/%0h want=7/44", wr_cyc, ex_addrs[0]); end
      total++; if (pkt_cnt_o !== 9 || hit_cnt_o !== 8) begin bad++; $display("FAIL b2b_cnt got=%0d/%0d want=9/8", pkt_cnt_o, hit_cnt_o); end
   endtask

   task automatic test_watchdog;
      cfg_len(1);
      run_pkt(4'b0001, -1, 0, 0, 1, 0, 40);
      total++; if (mt_cyc !== 3) begin bad++; $display("FAIL wd_mt_cyc got=%0d want=3", mt_cyc); end
`ifdef PROC_WATCHDOG_EN
      total++; if (err_n !== 1 || err_cyc !== 19) begin bad++; $display("FAIL wd_err got=%0d@%0d want=1@19", err_n, err_cyc); end
      total++; if (rd_n !== 1 || rd_cyc !== 19 || wr_n !== 0) begin bad++; $display("FAIL wd_rd got=%0d@%0d wr=%0d want=1@19 wr=0", rd_n, rd_cyc, wr_n); end
      total++; if (timeout_cnt_o !== 1 || drop_cnt_o !== 2) begin bad++; $display("FAIL wd_cnt got=%0d/%0d want=1/2", timeout_cnt_o, drop_cnt_o); end
      total++; if (free_cyc !== 20) begin bad++; $display("FAIL wd_free_cyc got=%0d want=20", free_cyc); end
`else
      total++; if (err_n !== 0 || rd_n !== 0) begin bad++; $display("FAIL nowd_err_rd got=%0d/%0d want=0/0", err_n, rd_n); end
      total++; if (cfg_busy_o !== 1'b1 || timeout_cnt_o !== 0) begin bad++; $display("FAIL nowd_hold got=%b/%0d want=1/0", cfg_busy_o, timeout_cnt_o); end
`endif
   endtask

   task automatic test_reset_mid_exec;
      rst = 1'b1; tick; rst = 1'b0;
      cfg_write(0, 32'h44, 32'h45);
      cfg_len(3);
      run_pkt(4'b0001, -1, 0, 0, 2, 0, 8);
      total++; if (ex_op_start_cnt_o !== 32'h44 || cfg_busy_o !== 1'b1 || rd_n !== 0) begin bad++; $display("FAIL midexec_pre got=%0h/%b/%0d want=44/1/0", ex_op_start_cnt_o, cfg_busy_o, rd_n); end
      rst = 1'b1;
      tick;
      total++; if ({ps_start_o, mt_start_o, ex_start_o, in_rd_o, out_wr_o, cfg_busy_o, err_o} !== 7'b0) begin bad++; $display("FAIL midexec_pulses got=%b want=0", {ps_start_o, mt_start_o, ex_start_o, in_rd_o, out_wr_o, cfg_busy_o, err_o}); end
      total++; if (ex_op_start_cnt_o !== 32'h0 || pkt_cnt_o !== 0 || hit_cnt_o !== 0 || drop_cnt_o !== 0) begin bad++; $display("FAIL midexec_regs got=%0h/%0d/%0d/%0d want=0", ex_op_start_cnt_o, pkt_cnt_o, hit_cnt_o, drop_cnt_o); end
      rst = 1'b0;
      run_pkt(4'b0001, -1, 0, 0, 0, 0, 60);
      total++; if (mt_n !== 1 || ex_addrs[0] !== 32'h0) begin bad++; $display("FAIL postrst_cfg got=%0d/%0h want=1/0", mt_n, ex_addrs[0]); end
      total++; if (pkt_cnt_o !== 1 || hit_cnt_o !== 1 || wr_cyc !== 7) begin bad++; $display("FAIL postrst_pkt got=%0d/%0d@%0d want=1/1@7", pkt_cnt_o, hit_cnt_o, wr_cyc); end
   endtask

   initial begin
      rst = 1'b1; in_empty_i = 1'b1; out_full_i = 1'b0;
      ps_ready_i = 0; mt_ready_i = 0; mt_is_match_i = 0; ex_ready_i = 0; ex_drop_i = 0;
      cfg_we_i = 0; cfg_len_we_i = 0; cfg_stage_i = 0; cfg_hit_addr_i = 0; cfg_miss_addr_i = 0; cfg_num_stages_i = 0;
      test_reset;
      test_single_hit;
      test_three_stage;
      test_drop;
      test_backpressure;
      test_cfg_same_cycle;
      test_cfg_limits;
      test_back_to_back;
      test_watchdog;
      test_reset_mid_exec;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
